// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, one-cycle program-memory fetch, and stall/replay FSM (FETCH/HOLD/REPLAY).
// Latency: the word at pm_addr appears on ins one edge later. Stall holds the PC and emits NOPs.
// Optional stall-cycle counter is enabled by macro STALL_COUNT_EN; otherwise stall_cycles is tied to zero.
module instr_fetch_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        stall_pm,
    input  logic        jump_en,
    input  logic [7:0]  jump_addr,
    input  logic [19:0] ins_pm_in,
    output logic [7:0]  pm_addr,
    output logic [19:0] ins,
    output logic        ins_valid,
    output logic [1:0]  state,
    output logic [7:0]  stall_cycles
);
    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        REPLAY  = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    localparam logic [19:0] NOP = 20'h00000;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [19:0] ins_q, ins_d;
    logic [19:0] saved_ins_q, saved_ins_d;
    logic        ins_valid_q, ins_valid_d;

    // ILLEGAL needs no case of its own: it falls into the normal-fetch path.
    always_comb begin
        pc_d        = pc_q;
        ins_d       = NOP;
        ins_valid_d = 1'b0;
        saved_ins_d = saved_ins_q;
        state_d     = FETCH;
        if (jump_en) begin
            pc_d = jump_addr;
        end else if (stall) begin
            state_d = HOLD;
        end else if ((state_q == HOLD) && stall_pm) begin
            ins_d       = saved_ins_q;
            ins_valid_d = 1'b1;
            state_d     = REPLAY;
        end else begin
            ins_d       = ins_pm_in;
            ins_valid_d = 1'b1;
            saved_ins_d = ins_pm_in;
            pc_d        = pc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= 8'h00;
            ins_q       <= NOP;
            ins_valid_q <= 1'b0;
            saved_ins_q <= NOP;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            saved_ins_q <= saved_ins_d;
        end
    end

    assign pm_addr   = pc_q;
    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;
    assign state     = state_q;

`ifdef STALL_COUNT_EN
    logic [7:0] stall_cycles_q, stall_cycles_d;

    // Counts every stalled edge, including one overridden by a jump, and saturates.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 8'hFF))
            stall_cycles_d = stall_cycles_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            stall_cycles_q <= 8'h00;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;
`else
    assign stall_cycles = 8'h00;
`endif

endmodule
